// File: rtl/kp_window_gen.sv
// 3x3 sliding-window generator for raster-order pixels: two line buffers feed
// three column shift registers, producing one window per accepted pixel two cycles later.
module kp_window_gen #(
   parameter int DATA_WIDTH = 8,
   parameter int LINE_WIDTH = 640
) (
   input  logic                    i_clk,
   input  logic                    i_rstn,
   input  logic [DATA_WIDTH-1:0]   i_data,
   input  logic                    i_valid,
   input  logic                    i_sof,
   output logic [3*DATA_WIDTH-1:0] o_r0_data,
   output logic [3*DATA_WIDTH-1:0] o_r1_data,
   output logic [3*DATA_WIDTH-1:0] o_r2_data,
   output logic                    o_valid
);

   localparam int COL_W = (LINE_WIDTH > 1) ? $clog2(LINE_WIDTH) : 1;
   localparam logic [COL_W-1:0] COL_LAST      = COL_W'(LINE_WIDTH - 1);
   localparam logic [COL_W-1:0] COL_FIRST_WIN = COL_W'(2);
   localparam logic [COL_W-1:0] COL_ONE       = COL_W'(1);
   localparam logic [1:0]       ROWS_FULL     = 2'd2;

   // Reset asserts asynchronously but releases two clock edges after i_rstn rises.
   logic [1:0] rst_sync;
   logic       rst_n;

   always_ff @(posedge i_clk or negedge i_rstn) begin
      if (!i_rstn) begin
         rst_sync <= 2'b00;
      end else begin
         rst_sync <= {rst_sync[0], 1'b1};
      end
   end

   assign rst_n = rst_sync[1];

   // Raster position; i_sof overrides the stored position for the pixel it tags.
   logic [COL_W-1:0] col;
   logic [1:0]       rows_seen;
   logic [COL_W-1:0] col_eff;
   logic [1:0]       rows_eff;
   logic             win_ok;

   // NOTE: every signal assigned in always_comb gets a default up front so no latch can be inferred.
   always_comb begin
      col_eff  = col;
      rows_eff = rows_seen;
      if (i_sof) begin
         col_eff  = '0;
         rows_eff = '0;
      end
      win_ok = (rows_eff == ROWS_FULL) && (col_eff >= COL_FIRST_WIN);
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         col       <= '0;
         rows_seen <= '0;
      end else if (i_valid) begin
         if (col_eff == COL_LAST) begin
            col       <= '0;
            rows_seen <= (rows_eff == ROWS_FULL) ? ROWS_FULL : rows_eff + 2'd1;
         end else begin
            col       <= col_eff + COL_ONE;
            rows_seen <= rows_eff;
         end
      end
   end

   // Line buffers: lb1 holds row y-1, lb2 holds row y-2, both indexed by column.
   logic [DATA_WIDTH-1:0] lb1 [LINE_WIDTH];
   logic [DATA_WIDTH-1:0] lb2 [LINE_WIDTH];
   logic [DATA_WIDTH-1:0] lb1_rd;
   logic [DATA_WIDTH-1:0] lb2_rd;

   // NOTE: the line buffers are deliberately left out of reset so they map to plain RAM;
   // the valid pipeline guarantees their stale contents never reach a valid window.
   always_ff @(posedge i_clk) begin
      if (i_valid) begin
         lb1_rd       <= lb1[col_eff];
         lb2_rd       <= lb2[col_eff];
         lb1[col_eff] <= i_data;
         lb2[col_eff] <= lb1[col_eff];
      end
   end

   // Stage 1: accepted pixel alongside the column above it from both line buffers.
   logic                  s1_vld;
   logic                  s1_win;
   logic [DATA_WIDTH-1:0] s1_pix;

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_vld <= 1'b0;
         s1_win <= 1'b0;
         s1_pix <= '0;
      end else begin
         s1_vld <= i_valid;
         s1_win <= i_valid && win_ok;
         if (i_valid) begin
            s1_pix <= i_data;
         end
      end
   end

   // Stage 2: column shift registers, newest column in the top field.
   logic [3*DATA_WIDTH-1:0] sr0;
   logic [3*DATA_WIDTH-1:0] sr1;
   logic [3*DATA_WIDTH-1:0] sr2;
   logic                    s2_win;

   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         sr0    <= '0;
         sr1    <= '0;
         sr2    <= '0;
         s2_win <= 1'b0;
      end else begin
         s2_win <= s1_win;
         if (s1_vld) begin
            sr0 <= {lb2_rd, sr0[3*DATA_WIDTH-1:DATA_WIDTH]};
            sr1 <= {lb1_rd, sr1[3*DATA_WIDTH-1:DATA_WIDTH]};
            sr2 <= {s1_pix, sr2[3*DATA_WIDTH-1:DATA_WIDTH]};
         end
      end
   end

   // Output stage: windows load only when complete, otherwise the last one is held.
   always_ff @(posedge i_clk or negedge rst_n) begin
      if (!rst_n) begin
         o_valid   <= 1'b0;
         o_r0_data <= '0;
         o_r1_data <= '0;
         o_r2_data <= '0;
      end else begin
         o_valid <= s2_win;
         if (s2_win) begin
            o_r0_data <= sr0;
            o_r1_data <= sr1;
            o_r2_data <= sr2;
         end
      end
   end

endmodule

// File: tb/tb_kp_window_gen.sv
// Directed bench for kp_window_gen with a 4-pixel line; windows are predicted from
// frame coordinates and checked two edges after each pixel is accepted.
module tb_kp_window_gen;

   localparam int DW = 8;
   localparam int LW = 4;

   logic          i_clk;
   logic          i_rstn;
   logic [DW-1:0] i_data;
   logic          i_valid;
   logic          i_sof;
   logic [3*DW-1:0] o_r0_data;
   logic [3*DW-1:0] o_r1_data;
   logic [3*DW-1:0] o_r2_data;
   logic          o_valid;

   kp_window_gen #(.DATA_WIDTH(DW), .LINE_WIDTH(LW)) dut (
      .i_clk     (i_clk),
      .i_rstn    (i_rstn),
      .i_data    (i_data),
      .i_valid   (i_valid),
      .i_sof     (i_sof),
      .o_r0_data (o_r0_data),
      .o_r1_data (o_r1_data),
      .o_r2_data (o_r2_data),
      .o_valid   (o_valid)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   int total;
   int bad;
   int pulses;

   // Expectation pipeline: index 2 is due at the current check.
   logic        pv [3];
   logic [23:0] pe0 [3];
   logic [23:0] pe1 [3];
   logic [23:0] pe2 [3];

   function automatic logic [7:0] pix(int r, int c, logic [7:0] off);
      return 8'(16 * r + c) + off;
   endfunction

   function automatic logic [23:0] win(int r, int c, logic [7:0] off);
      return {pix(r, c, off), pix(r, c - 1, off), pix(r, c - 2, off)};
   endfunction

   task automatic clear_pipe();
      for (int i = 0; i < 3; i++) begin
         pv[i]  = 1'b0;
         pe0[i] = '0;
         pe1[i] = '0;
         pe2[i] = '0;
      end
   endtask

   task automatic step(input string tag, input logic v, input logic sof, input logic [7:0] d,
                       input logic ev, input logic [23:0] e0, input logic [23:0] e1,
                       input logic [23:0] e2);
      for (int i = 2; i > 0; i--) begin
         pv[i]  = pv[i-1];
         pe0[i] = pe0[i-1];
         pe1[i] = pe1[i-1];
         pe2[i] = pe2[i-1];
      end
      pv[0]  = ev;
      pe0[0] = e0;
      pe1[0] = e1;
      pe2[0] = e2;
      i_valid = v;
      i_sof   = sof;
      i_data  = d;
      @(posedge i_clk);
      #1;
      total++;
      if (o_valid !== pv[2]) begin
         bad++;
         $display("FAIL %s o_valid got=%b want=%b t=%0t", tag, o_valid, pv[2], $time);
      end
      if (pv[2]) begin
         total++;
         if ({o_r0_data, o_r1_data, o_r2_data} !== {pe0[2], pe1[2], pe2[2]}) begin
            bad++;
            $display("FAIL %s window got=%h/%h/%h want=%h/%h/%h t=%0t", tag,
                     o_r0_data, o_r1_data, o_r2_data, pe0[2], pe1[2], pe2[2], $time);
         end
      end
      if (o_valid === 1'b1) pulses++;
   endtask

   task automatic idle(input string tag, input int n);
      for (int i = 0; i < n; i++) step(tag, 1'b0, 1'b0, 8'h00, 1'b0, '0, '0, '0);
   endtask

   task automatic send(input string tag, input int r, input int c, input logic sof,
                       input logic [7:0] off);
      logic ev;
      ev = (r >= 2) && (c >= 2);
      step(tag, 1'b1, sof, pix(r, c, off), ev,
           ev ? win(r - 2, c, off) : 24'h0,
           ev ? win(r - 1, c, off) : 24'h0,
           ev ? win(r, c, off) : 24'h0);
   endtask

   task automatic send_frame(input string tag, input int rows, input logic sof,
                             input logic [7:0] off, input int gap);
      for (int r = 0; r < rows; r++) begin
         for (int c = 0; c < LW; c++) begin
            send(tag, r, c, sof && (r == 0) && (c == 0), off);
            if (gap > 0) idle(tag, gap);
         end
      end
   endtask

   task automatic do_reset();
      i_valid = 1'b0;
      i_sof   = 1'b0;
      i_rstn  = 1'b0;
      repeat (2) @(posedge i_clk);
      #1;
      i_rstn = 1'b1;
      clear_pipe();
      pulses = 0;
      idle("reset_release", 3);
   endtask

   task automatic check_pulses(input string tag, input int want);
      total++;
      if (pulses !== want) begin
         bad++;
         $display("FAIL %s pulse_count got=%0d want=%0d", tag, pulses, want);
      end
   endtask

   task automatic check_zero_outputs(input string tag);
      total++;
      if (o_valid !== 1'b0) begin
         bad++;
         $display("FAIL %s o_valid got=%b want=0", tag, o_valid);
      end
      total++;
      if ({o_r0_data, o_r1_data, o_r2_data} !== 72'h0) begin
         bad++;
         $display("FAIL %s data got=%h/%h/%h want=0", tag, o_r0_data, o_r1_data, o_r2_data);
      end
   endtask

   task automatic test_reset();
      i_rstn = 1'b1;
      repeat (2) @(posedge i_clk);
      #2;
      i_rstn = 1'b0;
      #1;
      check_zero_outputs("reset_async");
      do_reset();
      check_zero_outputs("reset_released");
   endtask

   task automatic test_frame();
      do_reset();
      send_frame("frame", 5, 1'b1, 8'h00, 0);
      idle("frame_flush", 3);
      check_pulses("frame", 6);
      total++;
      if (o_r2_data !== win(4, 3, 8'h00)) begin
         bad++;
         $display("FAIL frame_hold o_r2_data got=%h want=%h", o_r2_data, win(4, 3, 8'h00));
      end
   endtask

   task automatic test_gapped();
      do_reset();
      send_frame("gapped", 5, 1'b1, 8'h00, 2);
      idle("gapped_flush", 3);
      check_pulses("gapped", 6);
   endtask

   task automatic test_reset_mid_frame();
      do_reset();
      send_frame("midrst_pre", 3, 1'b1, 8'h00, 0);
      for (int c = 0; c < 3; c++) send("midrst_row3", 3, c, 1'b0, 8'h00);
      #2;
      i_rstn = 1'b0;
      #1;
      check_zero_outputs("midrst_async");
      repeat (2) @(posedge i_clk);
      #1;
      i_rstn = 1'b1;
      clear_pipe();
      pulses = 0;
      idle("midrst_release", 3);
      send_frame("midrst_new", 3, 1'b0, 8'h80, 0);
      idle("midrst_flush", 3);
      check_pulses("midrst_new", 2);
   endtask

   task automatic test_sof_mid_line();
      do_reset();
      for (int c = 0; c < LW; c++) send("sof_old", 0, c, c == 0, 8'h00);
      send("sof_old", 1, 0, 1'b0, 8'h00);
      send("sof_old", 1, 1, 1'b0, 8'h00);
      send_frame("sof_new", 3, 1'b1, 8'h40, 0);
      idle("sof_flush", 3);
      check_pulses("sof_mid_line", 2);
   endtask

   task automatic test_constant_image();
      do_reset();
      for (int r = 0; r < 4; r++) begin
         for (int c = 0; c < LW; c++) begin
            step("const", 1'b1, (r == 0) && (c == 0), 8'h80, (r >= 2) && (c >= 2),
                 24'h808080, 24'h808080, 24'h808080);
         end
      end
      idle("const_flush", 3);
      check_pulses("const", 4);
   endtask

   initial begin
      total   = 0;
      bad     = 0;
      pulses  = 0;
      i_rstn  = 1'b1;
      i_valid = 1'b0;
      i_sof   = 1'b0;
      i_data  = '0;
      clear_pipe();
      test_reset();
      test_frame();
      test_gapped();
      test_reset_mid_frame();
      test_sof_mid_line();
      test_constant_image();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
